pico_uart_rx_port: RTL and testbench
====================================

Name: pico_uart_rx_port

Overview:
Port-mapped UART receiver with a small receive FIFO. It feeds the KCPSM3 in_port in the pico serial-I/O system.
- Deserialises 8N1 frames from the rx pin using 16x oversampling.
- Buffers received bytes in a FIFO.
- Presents a data port and a status port, decoded from port_id. The FIFO is popped on read_strobe.
- rx_irq is available for the processor interrupt input.

Parameters:
DVSR, 163, clk cycles per oversample tick (50 MHz / (16 x 19200)).
DBIT, 8, data bits per frame.
SB_TICK, 16, oversample ticks in the stop bit.
FIFO_W, 2, FIFO address width (depth 2**FIFO_W = 4).
DATA_PORT, 8'h00, port_id that reads and pops the FIFO.
STATUS_PORT, 8'h01, port_id that reads status and clears the sticky flags.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
rx  in  1  serial line, idle high, asynchronous to clk.
port_id  in  8  KCPSM3 port address.
read_strobe  in  1  KCPSM3 read strobe, one clk wide.
in_port  out  8  read data to the KCPSM3 in_port, combinational from port_id.
rx_irq  out  1  registered FIFO-not-empty flag.

Behaviour:
- Reset (async, active-high):
  - Synchroniser flops are set to 1.
  - Tick counter is set to 0; FSM goes to idle; bit counter and shift register are set to 0.
  - FIFO pointers are set to 0 (FIFO empty); overrun and frame_err flags are cleared; rx_irq is set to 0.
  - Reset in the middle of a frame discards the partial byte. Reception restarts at the next falling edge after release.
- rx synchroniser: 2 flops, adding 2 clk of latency. Only the synchronised value is used.
- Tick generator:
  - Free-running mod-DVSR counter.
  - tick is a 1-clk pulse when the count equals DVSR-1.
- Receive FSM: s is the 4-bit tick counter, n is the bit counter, b is the shift register.
  - idle: when rx is 0, go to start and set s to 0.
  - start: on each tick, s increments. At s==7:
    - if rx is 0, go to data and set s=0, n=0;
    - if rx is 1 (false start or glitch), return to idle.
  - data: on each tick, s increments. At s==15:
    - shift the bit in LSB first, with b <= {rx, b[7:1]};
    - set s=0 and increment n;
    - after DBIT bits, go to stop.
  - stop: on each tick, s increments. At s==SB_TICK-1, sample rx and return to idle:
    - if rx is 1, pulse done for 1 clk;
    - if rx is 0, discard the byte and set frame_err.
- FIFO:
  - Push on done. A simultaneous pop frees the slot, so a push while full with a same-cycle pop is accepted.
  - Push on full without a pop drops the byte, sets overrun, and leaves the contents unchanged.
  - Pop happens when read_strobe is high, port_id==DATA_PORT and the FIFO is not empty.
  - Pop on empty has no effect.
  - Pointers wrap modulo depth. full and empty are tracked with registered flags.
- in_port (combinational):
  - port_id==DATA_PORT: FIFO head, or 8'h00 when empty.
  - port_id==STATUS_PORT: {4'b0, frame_err, overrun, full, not_empty}.
  - Any other port_id: 8'h00.
- Sticky flags:
  - frame_err and overrun clear on read_strobe with port_id==STATUS_PORT.
  - The returned value is the pre-clear value.
  - If a set event and a clear happen in the same cycle, set wins.
- rx_irq <= not_empty, updated every clk.
- End-to-end latency: done, and the FIFO write, occur SB_TICK ticks into the stop bit. rx_irq rises 1 clk after the FIFO write.

Test Plan:
- Send 0xA5 at 19200 baud (bit = 2608 clk):
  - rx_irq rises during the stop bit;
  - status read returns 0x01;
  - data read returns 0xA5;
  - the next status read returns 0x00 and rx_irq falls 1 clk after the pop.
- Send 0x11,0x22,0x33,0x44,0x55 without reading:
  - status returns 0x07;
  - data reads return 0x11,0x22,0x33,0x44 (0x55 dropped);
  - a second status read returns 0x00 after the pops.
- Send 0x3C with stop bit 0: status returns 0x08, FIFO stays empty, the next status read returns 0x00.
- Drive rx low for 4 ticks then high: no byte is received, status stays 0x00, and a following 0x5A frame is received correctly.
- FIFO full: pop the data port in the same clk as done for 0x66:
  - no overrun;
  - reads return the 3 remaining bytes followed by 0x66.
- Assert reset during bit 4 of a frame:
  - rx_irq is 0 immediately and status is 0x00;
  - the next complete frame 0xC3 is received correctly.

Source files
------------

// File: rtl/pico_uart_rx_port_if.sv
// Processor-side port bundle for pico_uart_rx_port: KCPSM3 port address,
// read strobe and read data, plus the receive interrupt.
interface pico_uart_rx_port_if;
    logic [7:0] port_id;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       rx_irq;

    modport master (
        output port_id,
        output read_strobe,
        input  in_port,
        input  rx_irq
    );

    modport slave (
        input  port_id,
        input  read_strobe,
        output in_port,
        output rx_irq
    );
endinterface

// File: rtl/pico_uart_rx_port.sv
// 8N1 UART receiver with 16x oversampling, a small receive FIFO and a
// KCPSM3 port-mapped read interface (data port pops, status port clears flags).
module pico_uart_rx_port #(
    parameter int         DVSR        = 163,
    parameter int         DBIT        = 8,
    parameter int         SB_TICK     = 16,
    parameter int         FIFO_W      = 2,
    parameter logic [7:0] DATA_PORT   = 8'h00,
    parameter logic [7:0] STATUS_PORT = 8'h01
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    pico_uart_rx_port_if.slave   bus
);

    localparam int         CW       = $clog2(DVSR);
    localparam int         NW       = $clog2(DBIT);
    localparam int         DEPTH    = 1 << FIFO_W;
    localparam logic [CW-1:0] TICK_MAX = CW'(DVSR - 1);
    localparam logic [3:0] SB_LAST  = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Synchroniser and oversample tick
    // ------------------------------------------------------------------
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rx_s;
    logic          tick;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == TICK_MAX);

    always_comb begin
        sync_d = {sync_q[0], rx};
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
    end

    // NOTE: every flop is updated with <= so all of them sample pre-edge
    // values; combinational blocks use = and never touch the _q signals.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            done;
    logic            frame_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    // NOTE: each output gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        // Mid-start re-check rejects glitches shorter than half a bit.
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_q == SB_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done      = 1'b0;
        frame_set = 1'b0;
        if (state_q == ST_STOP && tick && s_q == SB_LAST) begin
            done      = rx_s;
            frame_set = !rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO and sticky flags
    // ------------------------------------------------------------------
    logic [7:0]        mem_q [DEPTH];
    logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_irq_q, rx_irq_d;
    logic              pop;
    logic              push;
    logic              status_rd;

    assign pop       = bus.read_strobe && (bus.port_id == DATA_PORT) && !empty_q;
    assign status_rd = bus.read_strobe && (bus.port_id == STATUS_PORT);
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    assign push      = done && (!full_q || pop);

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        full_d      = full_q;
        empty_d     = empty_q;
        unique case ({push, pop})
            2'b10: begin
                empty_d = 1'b0;
                full_d  = (wr_ptr_d == rd_ptr_q);
            end
            2'b01: begin
                full_d  = 1'b0;
                empty_d = (rd_ptr_d == wr_ptr_q);
            end
            default: ;
        endcase
        overrun_d   = (done && full_q && !pop) || (overrun_q && !status_rd);
        frame_err_d = frame_set || (frame_err_q && !status_rd);
        rx_irq_d    = !empty_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_irq_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_irq_q    <= rx_irq_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the empty flag
    // masks stale entries, and leaving it reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= 8'(b_q);
        end
    end

    // ------------------------------------------------------------------
    // Port-mapped read data
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_port = 8'h00;
        if (bus.port_id == DATA_PORT) begin
            if (!empty_q) begin
                bus.in_port = mem_q[rd_ptr_q];
            end
        end else if (bus.port_id == STATUS_PORT) begin
            bus.in_port = {4'b0000, frame_err_q, overrun_q, full_q, !empty_q};
        end
    end

    assign bus.rx_irq = rx_irq_q;

endmodule

// File: tb/tb_pico_uart_rx_port.sv
// Directed bench for pico_uart_rx_port: frames are driven on rx, a queue-based
// model tracks FIFO contents and sticky flags, and port reads are checked against it.
module tb_pico_uart_rx_port;

    localparam int DVSR    = 4;
    localparam int BIT_CLK = 16 * DVSR;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    pico_uart_rx_port_if bus ();

    pico_uart_rx_port #(
        .DVSR        (DVSR),
        .DBIT        (8),
        .SB_TICK     (16),
        .FIFO_W      (2),
        .DATA_PORT   (8'h00),
        .STATUS_PORT (8'h01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         busy   = 1'b1;
    logic [7:0] idle_id = 8'h01;
    logic       irq_end_data;
    logic       irq_end_stop;

    // Model state: received bytes in order, plus the two sticky flags.
    logic [7:0] m_q [$];
    bit         m_ovr;
    bit         m_ferr;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_port(input logic [7:0] id);
        if (id == 8'h00) return (m_q.size() != 0) ? m_q[0] : 8'h00;
        if (id == 8'h01) return {4'b0000, m_ferr, m_ovr, m_q.size() == 4, m_q.size() != 0};
        return 8'h00;
    endfunction

    function automatic void model_frame(input logic [7:0] d, input bit stop);
        if (!stop)                m_ferr = 1'b1;
        else if (m_q.size() < 4)  m_q.push_back(d);
        else                      m_ovr = 1'b1;
    endfunction

    function automatic void model_read(input logic [7:0] id);
        if (id == 8'h00 && m_q.size() != 0) void'(m_q.pop_front());
        if (id == 8'h01) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endfunction

    // Steady-state compare: whenever the bench is not mid-transaction the
    // interrupt and the currently addressed port must match the model.
    always @(negedge clk) begin
        if (!busy && !reset) begin
            check("irq_steady", 8'(bus.rx_irq), 8'(m_q.size() != 0));
            check("port_steady", bus.in_port, model_port(bus.port_id));
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit stop, input int stop_clk = BIT_CLK);
        busy = 1'b1;
        rx = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLK) @(posedge clk);
        end
        #1 irq_end_data = bus.rx_irq;
        rx = stop;
        repeat (stop_clk) @(posedge clk);
        #1 irq_end_stop = bus.rx_irq;
        rx = 1'b1;
        repeat (BIT_CLK) @(posedge clk);
        model_frame(d, stop);
        @(negedge clk);
        busy = 1'b0;
    endtask

    task automatic read_port(input logic [7:0] id, input logic [7:0] lit, input string name);
        bit         pre;
        bit         post;
        logic [7:0] exp;
        busy = 1'b1;
        @(negedge clk);
        bus.port_id     = id;
        bus.read_strobe = 1'b1;
        #1;
        exp = model_port(id);
        check({name, "_model"}, exp, lit);
        check(name, bus.in_port, exp);
        pre = (m_q.size() != 0);
        @(posedge clk);
        model_read(id);
        post = (m_q.size() != 0);
        @(negedge clk);
        bus.read_strobe = 1'b0;
        bus.port_id     = idle_id;
        check({name, "_irq_hold"}, 8'(bus.rx_irq), 8'(pre));
        @(negedge clk);
        check({name, "_irq_next"}, 8'(bus.rx_irq), 8'(post));
        @(negedge clk);
        busy = 1'b0;
    endtask

    task automatic set_idle(input logic [7:0] id);
        busy = 1'b1;
        @(negedge clk);
        idle_id     = id;
        bus.port_id = id;
        @(negedge clk);
        busy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] burst [5];
        logic [7:0] fill  [4];
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        fill  = '{8'h61, 8'h62, 8'h63, 8'h64};

        bus.port_id     = 8'h01;
        bus.read_strobe = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_irq", 8'(bus.rx_irq), 8'h00);
        check("reset_status", bus.in_port, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        busy = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte, then drain and pop on empty.
        send_frame(8'hA5, 1'b1);
        check("t1_irq_before_stop", 8'(irq_end_data), 8'h00);
        check("t1_irq_in_stop", 8'(irq_end_stop), 8'h01);
        read_port(8'h01, 8'h01, "t1_status");
        read_port(8'h00, 8'hA5, "t1_data");
        read_port(8'h01, 8'h00, "t1_status2");
        read_port(8'h00, 8'h00, "t1_pop_empty");

        // Five bytes into a depth-4 FIFO: last one overruns.
        set_idle(8'h00);
        for (int i = 0; i < 5; i++) send_frame(burst[i], 1'b1);
        read_port(8'h01, 8'h07, "t2_status");
        read_port(8'h00, 8'h11, "t2_data0");
        read_port(8'h00, 8'h22, "t2_data1");
        read_port(8'h00, 8'h33, "t2_data2");
        read_port(8'h00, 8'h44, "t2_data3");
        read_port(8'h01, 8'h00, "t2_status2");

        // Framing error: stop bit low (held 3/4 bit so the line is high again
        // before the receiver re-checks its next start bit).
        set_idle(8'h42);
        send_frame(8'h3C, 1'b0, 3 * BIT_CLK / 4);
        read_port(8'h01, 8'h08, "t3_status");
        read_port(8'h00, 8'h00, "t3_data_empty");
        read_port(8'h01, 8'h00, "t3_status2");

        // Short low glitch must be rejected; next frame still decodes.
        busy = 1'b1;
        rx = 1'b0;
        repeat (4 * DVSR) @(posedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        @(negedge clk);
        busy = 1'b0;
        read_port(8'h01, 8'h00, "t4_status");
        send_frame(8'h5A, 1'b1);
        read_port(8'h00, 8'h5A, "t4_data");

        // Full FIFO with a pop landing on the same clk as the push.
        set_idle(8'h01);
        for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1);
        read_port(8'h01, 8'h03, "t5_status_full");
        fork
            send_frame(8'h66, 1'b1);
            begin : pop_at_done
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 12 * BIT_CLK && !seen; i++) begin
                    @(negedge clk);
                    if (dut.done === 1'b1) begin
                        seen = 1'b1;
                        bus.port_id     = 8'h00;
                        bus.read_strobe = 1'b1;
                        #1;
                        check("t5_head_model", m_q[0], 8'h61);
                        check("t5_head", bus.in_port, m_q[0]);
                        @(posedge clk);
                        model_read(8'h00);
                        @(negedge clk);
                        bus.read_strobe = 1'b0;
                        bus.port_id     = idle_id;
                    end
                end
                check("t5_done_seen", 8'(seen), 8'h01);
            end
        join
        read_port(8'h01, 8'h03, "t5_status");
        read_port(8'h00, 8'h62, "t5_data0");
        read_port(8'h00, 8'h63, "t5_data1");
        read_port(8'h00, 8'h64, "t5_data2");
        read_port(8'h00, 8'h66, "t5_data3");
        read_port(8'h01, 8'h00, "t5_status2");

        // Reset mid-frame with a byte and a frame error pending.
        send_frame(8'h77, 1'b1);
        send_frame(8'h0F, 1'b0, 3 * BIT_CLK / 4);
        busy = 1'b1;
        @(negedge clk);
        check("t6_pre_status", bus.in_port, 8'h09);
        rx = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h99 >> i) & 8'h01;
            repeat (BIT_CLK) @(posedge clk);
        end
        rx = 1'b0;
        repeat (BIT_CLK / 2) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        #1;
        check("t6_rst_irq", 8'(bus.rx_irq), 8'h00);
        check("t6_rst_status", bus.in_port, 8'h00);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT_CLK) @(posedge clk);
        @(negedge clk);
        busy = 1'b0;
        read_port(8'h01, 8'h00, "t6_status");
        send_frame(8'hC3, 1'b1);
        read_port(8'h00, 8'hC3, "t6_data");
        read_port(8'h01, 8'h00, "t6_status2");

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
